spike_time_encoder: RTL and testbench

Binary-to-temporal encoder that drives race-logic compare blocks such as the pulse-width less-than unit. Each accepted vector holds NUM_CH spike times. In the following gamma cycle, every lane emits one PULSE_WIDTH-cycle pulse starting at its encoded tick; a lane with an out-of-range value emits no pulse, which means "infinity". The block also generates the gamma-cycle framing strobes, including the latch-set strobe consumed downstream.

---
 rtl/spike_time_encoder.sv | 106 ++++++++++
 tb/tb_spike_time_encoder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/spike_time_encoder.sv
// spike_time_encoder
//
// Binary-to-temporal encoder for race-logic compare blocks. Each accepted
// vector carries NUM_CH spike times. One gamma cycle later, every lane emits a
// single PULSE_WIDTH-cycle pulse that starts at its encoded tick. A lane whose
// value exceeds T_MAX emits nothing, which downstream logic reads as
// "infinity". The block also generates the gamma-cycle framing strobes.
//
// Ports:
//   aclk        - single clock
//   grst        - synchronous, active-high reset
//   in_valid    - in_times holds a vector
//   in_ready    - block can accept a vector this cycle
//   in_times    - NUM_CH unsigned spike times, lane i at [i*TW +: TW]
//   spikes      - temporal-coded pulses, one bit per lane
//   gamma_start - high on tick 0 of every gamma cycle
//   gamma_set   - high on the last tick of every gamma cycle (latch set)
//   cycle_valid - the current gamma cycle is playing a loaded vector

module spike_time_encoder #(
    parameter  int GAMMA_CYCLE_WIDTH = 16,
    parameter  int PULSE_WIDTH       = 8,
    parameter  int NUM_CH            = 4,
    localparam int TW                = $clog2(GAMMA_CYCLE_WIDTH),
    localparam int T_MAX             = GAMMA_CYCLE_WIDTH - 1 - PULSE_WIDTH
) (
    input  logic                 aclk,
    input  logic                 grst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NUM_CH*TW-1:0] in_times,
    output logic [NUM_CH-1:0]    spikes,
    output logic                 gamma_start,
    output logic                 gamma_set,
    output logic                 cycle_valid
);

    localparam logic [TW-1:0] TICK_LAST = TW'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    // One extra bit keeps v + PULSE_WIDTH - 1 from wrapping for large lane values.
    localparam logic [TW:0] T_MAX_EXT = (TW + 1)'(T_MAX);
    localparam logic [TW:0] PW_M1_EXT = (TW + 1)'(PULSE_WIDTH - 1);

    logic [TW-1:0]        tick;
    logic [NUM_CH*TW-1:0] pending;
    logic                 pending_v;
    logic [NUM_CH*TW-1:0] active;
    logic                 active_v;

    logic                 tick_wrap;
    logic                 xfer;

    assign tick_wrap = (tick == TICK_LAST);
    assign in_ready  = !pending_v && !grst;
    assign xfer      = in_valid && in_ready;

    // Tick counter plus the two-stage vector pipeline. The pending slot is
    // promoted to the active slot on the last tick of each gamma cycle. A
    // transfer on that same edge can only happen when pending was empty, so it
    // simply refills pending and plays in the gamma cycle after next.
    always_ff @(posedge aclk) begin
        if (grst) begin
            tick      <= '0;
            pending_v <= 1'b0;
            active_v  <= 1'b0;
        end else begin
            if (tick_wrap) begin
                tick      <= '0;
                active    <= pending;
                active_v  <= pending_v;
                pending_v <= 1'b0;
            end else begin
                tick <= tick + TICK_ONE;
            end

            if (xfer) begin
                pending   <= in_times;
                pending_v <= 1'b1;
            end
        end
    end

    // Pulse decode from registered state only. A lane is high while the tick
    // lies inside [v, v + PULSE_WIDTH - 1]; values above T_MAX never fire, so
    // the latest pulse ends one tick before gamma_set.
    always_comb begin
        logic [TW:0] v_ext;
        logic [TW:0] tick_ext;
        spikes   = '0;
        v_ext    = '0;
        tick_ext = {1'b0, tick};
        for (int i = 0; i < NUM_CH; i++) begin
            v_ext     = {1'b0, active[i*TW +: TW]};
            spikes[i] = active_v
                        && (v_ext <= T_MAX_EXT)
                        && (tick_ext >= v_ext)
                        && (tick_ext <= v_ext + PW_M1_EXT);
        end
    end

    assign gamma_start = (tick == '0);
    assign gamma_set   = tick_wrap;
    assign cycle_valid = active_v;

endmodule

// File: tb/tb_spike_time_encoder.sv
// tb_spike_time_encoder
//
// Directed scenarios followed by randomized traffic for spike_time_encoder.
// Expected behaviour comes from a reference model built on absolute time:
// the cycle count since reset gives the gamma index and tick, and each
// accepted vector is filed under the gamma cycle it must play in.

module tb_spike_time_encoder;

    localparam int G      = 16;
    localparam int P      = 8;
    localparam int NUM_CH = 4;
    localparam int TW     = $clog2(G);
    localparam int T_MAX  = G - 1 - P;
    localparam int VW     = NUM_CH * TW;

    logic          aclk;
    logic          grst;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_times;
    logic [NUM_CH-1:0] spikes;
    logic          gamma_start;
    logic          gamma_set;
    logic          cycle_valid;

    int checks;
    int errors;
    int cyc;
    bit lastXfer;

    // Reference model: gamma index -> vector scheduled to play in that gamma.
    logic [VW-1:0] playMap [int];

    spike_time_encoder #(
        .GAMMA_CYCLE_WIDTH(G),
        .PULSE_WIDTH      (P),
        .NUM_CH           (NUM_CH)
    ) dut (
        .aclk       (aclk),
        .grst       (grst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_times   (in_times),
        .spikes     (spikes),
        .gamma_start(gamma_start),
        .gamma_set  (gamma_set),
        .cycle_valid(cycle_valid)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Pulse pattern a vector produces at tick t, computed lane by lane.
    function automatic logic [NUM_CH-1:0] spikesFor(input logic [VW-1:0] vec, input int t);
        logic [NUM_CH-1:0] s;
        int v;
        s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            v = int'(vec[i*TW +: TW]);
            if (v <= T_MAX && t >= v && t < v + P) s[i] = 1'b1;
        end
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Drive one cycle of input, check every output against the model on the
    // falling edge, then record any transfer the model says takes place.
    task automatic applyStimulus(input logic valid, input logic [VW-1:0] times);
        int g;
        int t;
        logic expReady;
        logic expValid;
        logic [NUM_CH-1:0] expSp;
        in_valid = valid;
        in_times = times;
        @(negedge aclk);
        g        = cyc / G;
        t        = cyc % G;
        expValid = playMap.exists(g);
        expSp    = expValid ? spikesFor(playMap[g], t) : '0;
        expReady = !playMap.exists(g + 1);
        checkOutput("spikes",      32'(spikes),      32'(expSp));
        checkOutput("cycle_valid", 32'(cycle_valid), 32'(expValid));
        checkOutput("gamma_start", 32'(gamma_start), 32'(t == 0));
        checkOutput("gamma_set",   32'(gamma_set),   32'(t == G - 1));
        checkOutput("in_ready",    32'(in_ready),    32'(expReady));
        lastXfer = valid && expReady;
        if (lastXfer) playMap[(t == G - 1) ? g + 2 : g + 1] = times;
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    // Hold reset for n cycles with junk on the input, then restart the model.
    task automatic doReset(input int n);
        for (int i = 0; i < n; i++) begin
            grst     = 1'b1;
            in_valid = 1'b1;
            in_times = VW'($urandom);
            @(negedge aclk);
            checkOutput("in_ready_rst", 32'(in_ready), 32'(0));
            @(posedge aclk);
            #1;
        end
        grst     = 1'b0;
        in_valid = 1'b0;
        cyc      = 0;
        playMap.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0);
    endtask

    task automatic waitTick(input int t);
        while (cyc % G != t) applyStimulus(1'b0, '0);
    endtask

    // Hold a vector valid until it is accepted, bounded to a few gamma cycles.
    task automatic sendVector(input logic [VW-1:0] vec);
        int budget;
        budget   = 3 * G;
        lastXfer = 1'b0;
        while (!lastXfer && budget > 0) begin
            applyStimulus(1'b1, vec);
            budget--;
        end
        checks++;
        assert (lastXfer)
        else begin
            errors++;
            $error("[TB] FAIL send_timeout: observed no transfer expected transfer for %0h", vec);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        grst     = 1'b1;
        in_valid = 1'b0;
        in_times = '0;
        @(posedge aclk);
        #1;
        doReset(2);

        $display("[TB] scenario 1: single vector at tick 5");
        waitTick(5);
        sendVector({4'd8, 4'd7, 4'd0, 4'd3});
        idle(2 * G);

        $display("[TB] scenario 2: back-to-back vectors A then B");
        waitTick(2);
        sendVector({4'd1, 4'd2, 4'd3, 4'd4});
        sendVector({4'd7, 4'd6, 4'd5, 4'd0});
        idle(3 * G);

        $display("[TB] scenario 3: transfer on the load edge");
        waitTick(G - 1);
        applyStimulus(1'b1, {4'd0, 4'd7, 4'd2, 4'd5});
        idle(3 * G);

        $display("[TB] scenario 4: idle after reset");
        doReset(1);
        idle(3 * G);

        $display("[TB] scenario 5: reset mid-gamma with pending full");
        doReset(1);
        sendVector({4'd15, 4'd15, 4'd15, 4'd3});
        waitTick(0);
        sendVector({4'd0, 4'd1, 4'd2, 4'd4});
        waitTick(9);
        applyStimulus(1'b0, '0);
        doReset(1);
        idle(3 * G);

        $display("[TB] scenario 6: out-of-range lanes");
        sendVector({4'd15, 4'd9, 4'd8, 4'd7});
        idle(2 * G);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) doReset(1);
            else applyStimulus(1'($urandom_range(0, 1)), VW'($urandom));
        end
        idle(2 * G);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
